// File: rtl/wash_cycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// wash_cycle_pkg
// Shared types for the wash program controller.
//   state_t : program state encoding, also driven out on the state port.
//   act_t   : actuator bundle (door latch, inlet valve, drain pump, motor, spin).
//   actuator_map() : actuator values for a given state, pause and water level.
// -----------------------------------------------------------------------------
package wash_cycle_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WASH  = 3'd2,
        RINSE = 3'd3,
        DRAIN = 3'd4,
        SPIN  = 3'd5,
        DONE  = 3'd6,
        ERROR = 3'd7
    } state_t;

    typedef struct packed {
        logic door_lock;
        logic fill_valve;
        logic drain_pump;
        logic motor_on;
        logic motor_fast;
    } act_t;

    // Pause kills every moving part but keeps the door latched. ERROR keeps
    // draining regardless of pause so a faulted drum never stays full.
    function automatic act_t actuator_map(input state_t st, input logic pause,
                                          input logic water_full);
        act_t a;
        a = act_t'(5'b00000);
        case (st)
            FILL: begin
                a.door_lock  = 1'b1;
                a.fill_valve = ~pause & ~water_full;
            end
            WASH, RINSE: begin
                a.door_lock = 1'b1;
                a.motor_on  = ~pause;
            end
            DRAIN: begin
                a.door_lock  = 1'b1;
                a.drain_pump = ~pause;
            end
            SPIN: begin
                a.door_lock  = 1'b1;
                a.motor_on   = ~pause;
                a.motor_fast = ~pause;
                a.drain_pump = ~pause;
            end
            ERROR: begin
                a.door_lock  = 1'b1;
                a.drain_pump = 1'b1;
            end
            default: a = act_t'(5'b00000);
        endcase
        return a;
    endfunction

endpackage

// File: rtl/wash_cycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// wash_cycle_ctrl_if
// Front-panel / sensor inputs and driver / status outputs of the controller.
//   master : panel and sensor side (drives start, pause, door_closed, water_full)
//   slave  : controller side (drives actuators, state, rinse_pass,
//            phase_remaining, done, error)
// -----------------------------------------------------------------------------
interface wash_cycle_ctrl_if #(
    parameter int TIMER_W = 16
);
    logic               start;
    logic               pause;
    logic               door_closed;
    logic               water_full;
    logic               door_lock;
    logic               fill_valve;
    logic               drain_pump;
    logic               motor_on;
    logic               motor_fast;
    logic [2:0]         state;
    logic [2:0]         rinse_pass;
    logic [TIMER_W-1:0] phase_remaining;
    logic               done;
    logic               error;

    modport master (
        output start, pause, door_closed, water_full,
        input  door_lock, fill_valve, drain_pump, motor_on, motor_fast,
        input  state, rinse_pass, phase_remaining, done, error
    );

    modport slave (
        input  start, pause, door_closed, water_full,
        output door_lock, fill_valve, drain_pump, motor_on, motor_fast,
        output state, rinse_pass, phase_remaining, done, error
    );
endinterface

// File: rtl/wash_phase_timer.sv
// -----------------------------------------------------------------------------
// wash_phase_timer
// Loadable down-counter for phase durations. Load has priority; otherwise the
// count decrements when hold is low and stops at zero.
//   clk, rst_n : clock, async active-low reset (count clears to 0)
//   load       : load load_val this cycle
//   load_val   : value to load
//   hold       : freeze the count
//   count      : current count (registered)
//   zero       : count == 0
// -----------------------------------------------------------------------------
module wash_phase_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               hold,
    output logic [TIMER_W-1:0] count,
    output logic               zero
);

    logic [TIMER_W-1:0] count_r;

    // Countdown register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {TIMER_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (!hold && (count_r != {TIMER_W{1'b0}})) begin
            count_r <= count_r - {{(TIMER_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign zero  = (count_r == {TIMER_W{1'b0}});

endmodule

// File: rtl/wash_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// wash_cycle_ctrl
// Wash program sequencer: FILL, WASH, DRAIN, NUM_RINSE x (FILL, RINSE, DRAIN),
// SPIN, DONE. Timed phases last exactly their cycle count of unpaused cycles.
// Optional build macro FILL_TIMEOUT_EN adds a FILL watchdog that traps in
// ERROR (left only through rst_n).
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   wc    : panel/sensor inputs and actuator/status outputs (slave modport)
// All outputs are registered.
// -----------------------------------------------------------------------------
module wash_cycle_ctrl
    import wash_cycle_pkg::*;
#(
    parameter int TIMER_W      = 16,
    parameter int WASH_CYCLES  = 40,
    parameter int RINSE_CYCLES = 20,
    parameter int DRAIN_CYCLES = 10,
    parameter int SPIN_CYCLES  = 30,
    parameter int NUM_RINSE    = 2,
    parameter int FILL_TIMEOUT = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    wash_cycle_ctrl_if.slave wc
);

    state_t             state_r;
    state_t             state_nx_s;
    logic               start_prev_r;
    logic               start_rise_s;
    logic [2:0]         rinse_r;
    logic [2:0]         rinse_nx_s;
    logic               wash_done_r;
    logic               wash_done_nx_s;
    logic               phase_go_s;
    logic               tmr_load_s;
    logic [TIMER_W-1:0] tmr_load_val_s;
    logic [TIMER_W-1:0] tmr_count_s;
    logic               tmr_zero_s;
    act_t               act_nx_s;
    act_t               act_r;
    logic               done_r;
    logic               error_nx_s;
    logic               error_r;

`ifndef FILL_TIMEOUT_EN
    // Without the watchdog the FILL budget has no consumer; this empty
    // block keeps the parameter referenced so both builds share one port list.
    if (FILL_TIMEOUT < 1) begin : g_fill_timeout_unused
    end
`endif

    // Start edge detector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_prev_r <= 1'b0;
        end else begin
            start_prev_r <= wc.start;
        end
    end

    assign start_rise_s = wc.start & ~start_prev_r;
    // A timed phase ends when its count reads 0 and pause is low.
    assign phase_go_s   = tmr_zero_s & ~wc.pause;

    // State, rinse counter and wash-pass flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rinse_r     <= 3'd0;
            wash_done_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            rinse_r     <= rinse_nx_s;
            wash_done_r <= wash_done_nx_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s     = state_r;
        rinse_nx_s     = rinse_r;
        wash_done_nx_s = wash_done_r;
        case (state_r)
            IDLE: begin
                if (start_rise_s && wc.door_closed) begin
                    state_nx_s = FILL;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            FILL: begin
                if (wc.pause) begin
                    state_nx_s = FILL;
                end else if (wc.water_full) begin
                    // First fill of a program feeds the wash pass; later fills feed rinses.
                    if ((rinse_r == 3'd0) && !wash_done_r) begin
                        state_nx_s = WASH;
                    end else begin
                        state_nx_s = RINSE;
                    end
`ifdef FILL_TIMEOUT_EN
                end else if (tmr_zero_s) begin
                    state_nx_s = ERROR;
`endif
                end else begin
                    state_nx_s = FILL;
                end
            end
            WASH: begin
                if (phase_go_s) begin
                    state_nx_s     = DRAIN;
                    wash_done_nx_s = 1'b1;
                end else begin
                    state_nx_s = WASH;
                end
            end
            RINSE: begin
                if (phase_go_s) begin
                    state_nx_s = DRAIN;
                    rinse_nx_s = rinse_r + 3'd1;
                end else begin
                    state_nx_s = RINSE;
                end
            end
            DRAIN: begin
                if (phase_go_s) begin
                    if (rinse_r < 3'(NUM_RINSE)) begin
                        state_nx_s = FILL;
                    end else begin
                        state_nx_s = SPIN;
                    end
                end else begin
                    state_nx_s = DRAIN;
                end
            end
            SPIN: begin
                if (phase_go_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = SPIN;
                end
            end
            DONE: begin
                state_nx_s     = IDLE;
                rinse_nx_s     = 3'd0;
                wash_done_nx_s = 1'b0;
            end
            ERROR: begin
`ifdef FILL_TIMEOUT_EN
                state_nx_s = ERROR;
`else
                state_nx_s = IDLE;
`endif
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Timer reload on every state change; untimed states load 0
    always_comb begin
        tmr_load_s = (state_nx_s != state_r);
        case (state_nx_s)
            WASH:    tmr_load_val_s = TIMER_W'(WASH_CYCLES - 1);
            RINSE:   tmr_load_val_s = TIMER_W'(RINSE_CYCLES - 1);
            DRAIN:   tmr_load_val_s = TIMER_W'(DRAIN_CYCLES - 1);
            SPIN:    tmr_load_val_s = TIMER_W'(SPIN_CYCLES - 1);
`ifdef FILL_TIMEOUT_EN
            FILL:    tmr_load_val_s = TIMER_W'(FILL_TIMEOUT - 1);
`endif
            default: tmr_load_val_s = {TIMER_W{1'b0}};
        endcase
    end

    wash_phase_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_s),
        .load_val (tmr_load_val_s),
        .hold     (wc.pause),
        .count    (tmr_count_s),
        .zero     (tmr_zero_s)
    );

    // Output values for the state being entered, gated by the sampled pause
    always_comb begin
        act_nx_s = actuator_map(state_nx_s, wc.pause, wc.water_full);
`ifdef FILL_TIMEOUT_EN
        error_nx_s = (state_nx_s == ERROR);
`else
        error_nx_s = 1'b0;
`endif
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_r   <= act_t'(5'b00000);
            done_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            act_r   <= act_nx_s;
            done_r  <= (state_nx_s == DONE);
            error_r <= error_nx_s;
        end
    end

    assign wc.door_lock       = act_r.door_lock;
    assign wc.fill_valve      = act_r.fill_valve;
    assign wc.drain_pump      = act_r.drain_pump;
    assign wc.motor_on        = act_r.motor_on;
    assign wc.motor_fast      = act_r.motor_fast;
    assign wc.state           = state_r;
    assign wc.rinse_pass      = rinse_r;
    assign wc.phase_remaining = tmr_count_s;
    assign wc.done            = done_r;
    assign wc.error           = error_r;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wash_cycle_ctrl
// Self-checking bench for wash_cycle_ctrl. A reference model walks a list of
// program phases with an elapsed-cycle counter; every cycle all DUT outputs are
// compared with it. Directed scenarios are followed by randomized stimulus.
// Honors FILL_TIMEOUT_EN for the watchdog scenario.
// -----------------------------------------------------------------------------
module tb_wash_cycle_ctrl;

    localparam int TW        = 16;
    localparam int P_WASH    = 4;
    localparam int P_RINSE   = 3;
    localparam int P_DRAIN   = 2;
    localparam int P_SPIN    = 5;
    localparam int P_NRINSE  = 1;
    localparam int P_FILL_TO = 8;

    localparam int S_IDLE = 0, S_FILL = 1, S_WASH = 2, S_RINSE = 3;
    localparam int S_DRAIN = 4, S_SPIN = 5, S_DONE = 6, S_ERROR = 7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wash_cycle_ctrl_if #(.TIMER_W(TW)) wc();

    wash_cycle_ctrl #(
        .TIMER_W      (TW),
        .WASH_CYCLES  (P_WASH),
        .RINSE_CYCLES (P_RINSE),
        .DRAIN_CYCLES (P_DRAIN),
        .SPIN_CYCLES  (P_SPIN),
        .NUM_RINSE    (P_NRINSE),
        .FILL_TIMEOUT (P_FILL_TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wc    (wc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int plan[$];
    bit m_active, m_err, m_prev, m_pause, m_water;
    int m_idx, m_el, m_rinses;

    bit auto_water;
    int fill_age;
    bit rec;
    int trace[$];
    int done_cnt, done_rinse;
    int rs[$], rl[$];
    int exp_s[9];
    int exp_l[8];
    int n;

    function automatic int dur(input int ph);
        case (ph)
            S_WASH:  return P_WASH;
            S_RINSE: return P_RINSE;
            S_DRAIN: return P_DRAIN;
            S_SPIN:  return P_SPIN;
            default: return 0;
        endcase
    endfunction

    function automatic int cur_phase();
        if (m_err) return S_ERROR;
        if (!m_active) return S_IDLE;
        return plan[m_idx];
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_err = 1'b0; m_prev = 1'b0;
        m_pause = 1'b0; m_water = 1'b0;
        m_idx = 0; m_el = 0; m_rinses = 0;
    endtask

    task automatic model_step();
        bit rise;
        int ph;
        rise    = wc.start && !m_prev;
        m_prev  = wc.start;
        m_pause = wc.pause;
        m_water = wc.water_full;
        ph      = cur_phase();
        if (ph == S_ERROR) begin
            m_err = 1'b1;
        end else if (ph == S_IDLE) begin
            if (rise && wc.door_closed) begin
                m_active = 1'b1; m_idx = 0; m_el = 0;
            end
        end else if (ph == S_DONE) begin
            m_active = 1'b0; m_rinses = 0;
        end else if (wc.pause) begin
            m_el = m_el;
        end else if (ph == S_FILL) begin
            if (wc.water_full) begin
                m_idx++; m_el = 0;
            end else begin
`ifdef FILL_TIMEOUT_EN
                if (m_el == P_FILL_TO - 1) m_err = 1'b1;
                else m_el++;
`endif
            end
        end else begin
            if (m_el == dur(ph) - 1) begin
                if (ph == S_RINSE) m_rinses++;
                m_idx++; m_el = 0;
            end else begin
                m_el++;
            end
        end
    endtask

    task automatic check_all();
        int ph, rem;
        bit run;
        ph  = cur_phase();
        run = !m_pause;
        rem = 0;
        if (dur(ph) > 0) rem = dur(ph) - 1 - m_el;
`ifdef FILL_TIMEOUT_EN
        if (ph == S_FILL) rem = P_FILL_TO - 1 - m_el;
`endif
        check_value("state", wc.state, ph);
        check_value("phase_remaining", wc.phase_remaining, rem);
        check_value("rinse_pass", wc.rinse_pass, m_rinses);
        check_value("door_lock", wc.door_lock, (ph != S_IDLE) && (ph != S_DONE));
        check_value("fill_valve", wc.fill_valve, (ph == S_FILL) && run && !m_water);
        check_value("drain_pump", wc.drain_pump,
                    (((ph == S_DRAIN) || (ph == S_SPIN)) && run) || (ph == S_ERROR));
        check_value("motor_on", wc.motor_on,
                    ((ph == S_WASH) || (ph == S_RINSE) || (ph == S_SPIN)) && run);
        check_value("motor_fast", wc.motor_fast, (ph == S_SPIN) && run);
        check_value("done", wc.done, ph == S_DONE);
        check_value("error", wc.error, ph == S_ERROR);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        if (rec) trace.push_back(int'(wc.state));
        if (rec && wc.done === 1'b1) begin
            done_cnt++;
            done_rinse = int'(wc.rinse_pass);
        end
        if (cur_phase() == S_FILL) fill_age++;
        else fill_age = 0;
        if (auto_water) wc.water_full = (fill_age >= 3);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        fill_age = 0;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_state(input int s, input int budget, input string tag);
        int k;
        k = 0;
        while (wc.state !== 3'(s) && k < budget) begin
            tick();
            k++;
        end
        check_value(tag, wc.state, s);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
        $fatal(1, "bench time limit");
    end

    initial begin
        plan.push_back(S_FILL); plan.push_back(S_WASH); plan.push_back(S_DRAIN);
        for (int i = 0; i < P_NRINSE; i++) begin
            plan.push_back(S_FILL); plan.push_back(S_RINSE); plan.push_back(S_DRAIN);
        end
        plan.push_back(S_SPIN); plan.push_back(S_DONE);
        exp_s = '{S_FILL, S_WASH, S_DRAIN, S_FILL, S_RINSE, S_DRAIN, S_SPIN, S_DONE, S_IDLE};
        exp_l = '{3, P_WASH, P_DRAIN, 3, P_RINSE, P_DRAIN, P_SPIN, 1};

        rst_n = 1'b0;
        wc.start = 1'b0; wc.pause = 1'b0; wc.door_closed = 1'b0; wc.water_full = 1'b0;
        auto_water = 1'b1; fill_age = 0; rec = 1'b0; done_cnt = 0; done_rinse = 0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Full program with repeated start edges during RINSE
        wc.door_closed = 1'b1;
        wc.start = 1'b1;
        rec = 1'b1;
        tick();
        wc.start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (wc.state == 3'(S_RINSE)) wc.start = 1'($urandom_range(0, 1));
            else wc.start = 1'b0;
            tick();
        end
        rec = 1'b0;
        foreach (trace[i]) begin
            if (i == 0 || trace[i] != trace[i-1]) begin
                rs.push_back(trace[i]);
                rl.push_back(1);
            end else begin
                rl[rl.size()-1]++;
            end
        end
        check_value("seq_phase_count", rs.size(), 9);
        for (int i = 0; i < 9; i++)
            if (i < rs.size()) check_value($sformatf("seq_state[%0d]", i), rs[i], exp_s[i]);
        for (int i = 0; i < 8; i++)
            if (i < rl.size()) check_value($sformatf("seq_len[%0d]", i), rl[i], exp_l[i]);
        check_value("done_pulses", done_cnt, 1);
        check_value("rinse_at_done", done_rinse, 1);

        // Door open: start edge dropped, not queued
        wc.door_closed = 1'b0;
        tick();
        wc.start = 1'b1;
        tick();
        tick();
        check_value("door_open_state", wc.state, S_IDLE);
        check_value("door_open_lock", wc.door_lock, 0);
        wc.door_closed = 1'b1;
        tick();
        tick();
        check_value("door_late_state", wc.state, S_IDLE);
        wc.start = 1'b0;
        tick();

        // Pause in WASH at timer 2, then pause with timer 0 in DRAIN
        wc.start = 1'b1;
        tick();
        wc.start = 1'b0;
        n = 0;
        while (!(wc.state == 3'(S_WASH) && wc.phase_remaining == TW'(2)) && n < 50) begin
            tick();
            n++;
        end
        check_value("reach_wash_t2", wc.state, S_WASH);
        wc.pause = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_value("pause_timer_hold", wc.phase_remaining, 2);
            check_value("pause_motor_off", wc.motor_on, 0);
        end
        wc.pause = 1'b0;
        n = 0;
        while (wc.state == 3'(S_WASH) && n < 10) begin
            tick();
            n++;
        end
        check_value("wash_after_pause", n, 3);
        n = 0;
        while (!(wc.state == 3'(S_DRAIN) && wc.phase_remaining == TW'(0)) && n < 20) begin
            tick();
            n++;
        end
        check_value("reach_drain_t0", wc.state, S_DRAIN);
        wc.pause = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_value("pause_t0_no_exit", wc.state, S_DRAIN);
        wc.pause = 1'b0;
        wait_state(S_IDLE, 60, "pause_prog_end");

        // Asynchronous reset in the middle of SPIN
        wc.start = 1'b1;
        tick();
        wc.start = 1'b0;
        wait_state(S_SPIN, 60, "reach_spin");
        tick();
        do_reset();
        tick();
        check_value("after_reset_idle", wc.state, S_IDLE);

`ifdef FILL_TIMEOUT_EN
        // Fill watchdog: no water for FILL_TIMEOUT cycles traps in ERROR
        auto_water = 1'b0;
        wc.water_full = 1'b0;
        wc.start = 1'b1;
        tick();
        wc.start = 1'b0;
        n = 0;
        while (wc.state == 3'(S_FILL) && n < 30) begin
            tick();
            n++;
        end
        check_value("fill_timeout_cycles", n, P_FILL_TO);
        check_value("err_state", wc.state, S_ERROR);
        check_value("err_flag", wc.error, 1);
        check_value("err_drain", wc.drain_pump, 1);
        check_value("err_lock", wc.door_lock, 1);
        for (int i = 0; i < 5; i++) tick();
        check_value("err_sticky", wc.state, S_ERROR);
        do_reset();
        auto_water = 1'b1;
`endif

        // Randomized stimulus against the model
        auto_water = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            wc.pause = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) wc.start = ~wc.start;
            wc.door_closed = ($urandom_range(0, 3) != 0);
            wc.water_full  = (cur_phase() == S_FILL) && ($urandom_range(0, 2) == 0);
            tick();
            if (cur_phase() == S_ERROR || $urandom_range(0, 399) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wash_cycle_ctrl.md
Name: wash_cycle_ctrl

Overview:
- Parametrised successor to the single-start washing machine controller.
- Sequences a full wash program: fill, wash, drain, N rinse passes (fill/rinse/drain each), spin, done.
- Adds configurable phase durations, rinse count, pause, door interlock and per-phase status.
- Sits between the front-panel inputs/sensors and the valve, pump and motor drivers.

Parameters:
- TIMER_W, 16, width of the phase countdown timer.
- WASH_CYCLES, 40, clock cycles of motor agitation in WASH; range 1..2^TIMER_W-1.
- RINSE_CYCLES, 20, clock cycles of agitation per RINSE; range 1..2^TIMER_W-1.
- DRAIN_CYCLES, 10, clock cycles of drain-pump run per DRAIN; range 1..2^TIMER_W-1.
- SPIN_CYCLES, 30, clock cycles of fast spin; range 1..2^TIMER_W-1.
- NUM_RINSE, 2, rinse passes after the wash pass; range 0..7.
- FILL_TIMEOUT, 100, maximum FILL cycles before a fault; used only with FILL_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level input; a 0->1 transition is detected internally.
- pause  in  1  level input; 1 freezes the current phase.
- door_closed  in  1  door sensor.
- water_full  in  1  level sensor.
- door_lock  out  1  door latch; 1 in every state except IDLE and DONE.
- fill_valve  out  1  inlet valve.
- drain_pump  out  1  drain pump.
- motor_on  out  1  drum motor enable.
- motor_fast  out  1  spin-speed select.
- state  out  3  current state encoding (from the package).
- rinse_pass  out  3  completed rinse passes.
- phase_remaining  out  TIMER_W  timer value.
- done  out  1  one-cycle completion pulse.
- error  out  1  fill-timeout fault flag.

Behaviour:
- Reset: async on rst_n=0. State=IDLE; all outputs 0; the start edge-detect register is cleared to 0.
- All outputs are registered. Actuator outputs are a function of the registered state and pause.
- IDLE:
  - Leave IDLE only on a start rising edge with door_closed=1; next state is FILL.
  - A start edge while door_closed=0 is dropped, not queued.
  - On entry, rinse_pass is cleared to 0.
- FILL:
  - fill_valve=1 while water_full=0.
  - On water_full=1: go to WASH if rinse_pass==0 and the wash pass is not done, otherwise RINSE.
  - FILL is not timed. phase_remaining=0 unless FILL_TIMEOUT_EN is defined.
- WASH / RINSE / DRAIN / SPIN:
  - On entry the timer is loaded with DURATION-1.
  - The timer decrements each unpaused cycle.
  - The state exits on the cycle where the timer reads 0 and pause=0, so each phase lasts exactly DURATION unpaused cycles.
- Actuators per state:
  - WASH and RINSE: motor_on=1.
  - DRAIN: drain_pump=1.
  - SPIN: motor_on=1, motor_fast=1, drain_pump=1.
- Transitions:
  - WASH->DRAIN.
  - RINSE->DRAIN; rinse_pass increments when leaving RINSE.
  - DRAIN->FILL if rinse_pass<NUM_RINSE, otherwise SPIN.
  - SPIN->DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - With NUM_RINSE=0 the sequence is FILL->WASH->DRAIN->SPIN.
- Pause:
  - While pause=1 in any active state, the timer holds and the state holds.
  - fill_valve, drain_pump, motor_on and motor_fast are forced to 0; door_lock stays 1.
  - Pause and timer==0 in the same cycle: pause wins and there is no exit.
  - pause has no effect in IDLE.
- Start edges outside IDLE are ignored.
- door_closed is ignored after leaving IDLE; the lock holds the door.
- Reset mid-program aborts immediately to IDLE with all actuators off.

Optional Feature:
- FILL_TIMEOUT_EN defined:
  - The timer loads FILL_TIMEOUT-1 on entry to FILL and decrements each unpaused FILL cycle.
  - If it reaches 0 without water_full, go to ERROR.
  - ERROR: error=1, drain_pump=1, door_lock=1, all other actuators 0.
  - ERROR is left only via rst_n.
- Not defined:
  - No ERROR state; error is tied to 0.
  - FILL waits indefinitely for water_full.

Decomposition:
- Package wash_cycle_pkg holds:
  - State enum: IDLE=0, FILL=1, WASH=2, RINSE=3, DRAIN=4, SPIN=5, DONE=6, ERROR=7.
  - Actuator bundle struct.
- Sub-module wash_phase_timer: loadable countdown with hold input, zero flag and TIMER_W parameter.

Test Plan:
Bench parameters for all scenarios: WASH=4, RINSE=3, DRAIN=2, SPIN=5, NUM_RINSE=1.
- Full program: door_closed=1, start 0->1, water_full=1 3 cycles after FILL entry each pass.
  - Required state order: FILL, WASH(4 cycles), DRAIN(2), FILL, RINSE(3), DRAIN(2), SPIN(5), DONE(1), IDLE.
  - done is high exactly 1 cycle; rinse_pass=1 at DONE.
- Door open: start edge with door_closed=0 -> state stays IDLE and door_lock=0.
  - A later door_closed=1 with no new start edge -> still IDLE.
- Pause: pause=1 for 6 cycles when WASH timer=2 -> timer holds at 2 and motor_on=0.
  - After release, WASH lasts 3 more cycles.
  - Pause and timer==0 together -> no transition.
- Reset mid-SPIN: rst_n=0 asynchronously -> all outputs 0 before the next clk edge; state=IDLE.
- Repeated start: start edges during RINSE -> no effect on sequence or timing.
- FILL_TIMEOUT_EN with FILL_TIMEOUT=8 and water_full held 0 -> ERROR after 8 FILL cycles.
  - error=1, drain_pump=1, door_lock=1; stays there until rst_n.
